// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit seven-segment display controller.
// Provides the digit width, the largest displayable value and the state
// encoding of the binary-to-BCD conversion FSM.
package seg_pkg;

    localparam int SEG_DIGIT_W   = 4;
    localparam int SEG_MAX_VALUE = 99;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } seg_state_t;

endpackage

// File: rtl/seg_blink_prescaler.sv
// Blink prescaler for the seven-segment display.
// While enabled, a counter runs 0..BLINK_DIV-1 and the phase output toggles
// each time the counter wraps. When disabled, the counter and phase are held
// at 0, so blinking always restarts from the visible half-period.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   en    - run the prescaler
//   phase - blink phase, 1 during the blanked half-period
module seg_blink_prescaler #(
    parameter int BLINK_DIV = 6_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase
);

    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= 1'b0;
        end else if (!en) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == CNT_LAST) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_ctrl.sv
// Sequencing controller for the two-digit seven-segment display.
// Accepts an 8-bit binary value over a valid/ready handshake, clamps it to 99,
// converts it to tens/units by repeated subtraction of ten and presents the
// digits only once the conversion is complete. Also produces per-digit blank
// strobes for blinking and leading-zero suppression.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - a new value is offered
//   in_ready   - controller can accept a value (IDLE)
//   in_value   - binary value to display
//   blink_en   - blink both digits
//   seg_data_1 - tens digit, 0-9
//   seg_data_2 - units digit, 0-9
//   blank_1    - suppress tens digit
//   blank_2    - suppress units digit
//   ovf        - last accepted value exceeded 99
module seg_ctrl
    import seg_pkg::*;
#(
    parameter int BLINK_DIV   = 6_000_000,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_value,
    input  logic                   blink_en,
    output logic [SEG_DIGIT_W-1:0] seg_data_1,
    output logic [SEG_DIGIT_W-1:0] seg_data_2,
    output logic                   blank_1,
    output logic                   blank_2,
    output logic                   ovf
);

    localparam logic [7:0] MAX_VALUE = 8'(SEG_MAX_VALUE);
    localparam logic       LZ_ON     = (LZ_SUPPRESS != 0);

    seg_state_t             state;
    seg_state_t             state_next;
    logic [6:0]             remainder;
    logic [SEG_DIGIT_W-1:0] tens;
    logic                   accept;
    logic                   commit;
    logic                   phase;
    logic [6:0]             clamped;

    // Clamping before loading keeps remainder within 7 bits and tens within 0-9.
    assign clamped = (in_value > MAX_VALUE) ? MAX_VALUE[6:0] : in_value[6:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (remainder < 7'd10) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Working registers are separate from the output digits so that a partial
    // result is never visible; the outputs move only on the commit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remainder  <= '0;
            tens       <= '0;
            ovf        <= 1'b0;
            seg_data_1 <= '0;
            seg_data_2 <= '0;
        end else if (accept) begin
            remainder <= clamped;
            tens      <= '0;
            ovf       <= (in_value > MAX_VALUE);
        end else if (commit) begin
            seg_data_1 <= tens;
            seg_data_2 <= remainder[SEG_DIGIT_W-1:0];
        end else if (state == CONV) begin
            remainder <= remainder - 7'd10;
            tens      <= tens + 4'd1;
        end
    end

    seg_blink_prescaler #(
        .BLINK_DIV(BLINK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (blink_en),
        .phase(phase)
    );

    assign blank_2 = blink_en & phase;
    assign blank_1 = (blink_en & phase) | (LZ_ON & (seg_data_1 == '0));

endmodule

// File: tb/tb_seg_ctrl.sv
// Self-checking bench for seg_ctrl: table of directed conversions plus
// hand-written sequences for held valid, blinking, async reset and
// leading-zero suppression disabled.
module tb_seg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_value = 8'd0;
    logic       blink_en = 1'b0;
    logic [3:0] seg_data_1;
    logic [3:0] seg_data_2;
    logic       blank_1;
    logic       blank_2;
    logic       ovf;

    logic       nz_valid = 1'b0;
    logic       nz_ready;
    logic [7:0] nz_value = 8'd0;
    logic [3:0] nz_data_1;
    logic [3:0] nz_data_2;
    logic       nz_blank_1;
    logic       nz_blank_2;
    logic       nz_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seg_ctrl #(.BLINK_DIV(4), .LZ_SUPPRESS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .blink_en  (blink_en),
        .seg_data_1(seg_data_1),
        .seg_data_2(seg_data_2),
        .blank_1   (blank_1),
        .blank_2   (blank_2),
        .ovf       (ovf)
    );

    seg_ctrl #(.BLINK_DIV(4), .LZ_SUPPRESS(0)) dut_nz (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (nz_valid),
        .in_ready  (nz_ready),
        .in_value  (nz_value),
        .blink_en  (1'b0),
        .seg_data_1(nz_data_1),
        .seg_data_2(nz_data_2),
        .blank_1   (nz_blank_1),
        .blank_2   (nz_blank_2),
        .ovf       (nz_ovf)
    );

    typedef struct {
        logic [7:0] value;
        int         tens;
        int         units;
        int         ovf;
        int         blank1;
        int         cycles;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Offers v at a negedge, waits for the accept edge, then counts the
    // cycles in_ready stays low. Ends on the negedge after the commit edge.
    task automatic applyStimulus(input logic [7:0] v, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_value = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!in_ready && lat < 50) begin
            lat++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int k;

        vecs[0] = '{8'd57,  5, 7, 0, 0, 6};
        vecs[1] = '{8'd0,   0, 0, 0, 1, 1};
        vecs[2] = '{8'd9,   0, 9, 0, 1, 1};
        vecs[3] = '{8'd10,  1, 0, 0, 0, 2};
        vecs[4] = '{8'd99,  9, 9, 0, 0, 10};
        vecs[5] = '{8'd100, 9, 9, 1, 0, 10};
        vecs[6] = '{8'd255, 9, 9, 1, 0, 10};
        vecs[7] = '{8'd90,  9, 0, 0, 0, 10};
        vecs[8] = '{8'd42,  4, 2, 0, 0, 5};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset seg_data_1", seg_data_1, 0);
        checkOutput("reset seg_data_2", seg_data_2, 0);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset ovf", ovf, 0);
        checkOutput("reset blank_1", blank_1, 1);
        checkOutput("reset blank_2", blank_2, 0);
        checkOutput("reset nz blank_1", nz_blank_1, 0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].value, lat);
            $display("[TB] vector %0d value %0d", i, vecs[i].value);
            checkOutput("vec latency", lat, vecs[i].cycles);
            checkOutput("vec tens", seg_data_1, vecs[i].tens);
            checkOutput("vec units", seg_data_2, vecs[i].units);
            checkOutput("vec ovf", ovf, vecs[i].ovf);
            checkOutput("vec blank_1", blank_1, vecs[i].blank1);
            checkOutput("vec blank_2", blank_2, 0);
        end

        // Blinking on 42: both blanks follow phase, which toggles every 4 edges.
        @(negedge clk);
        blink_en = 1'b1;
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput("blink blank_1", blank_1, (k / 4) % 2);
            checkOutput("blink blank_2", blank_2, (k / 4) % 2);
        end
        blink_en = 1'b0;
        @(negedge clk);
        checkOutput("blink off blank_1", blank_1, 0);
        checkOutput("blink off blank_2", blank_2, 0);

        // 150 with 3 held valid throughout the conversion.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 8'd150;
        @(posedge clk);
        @(negedge clk);
        in_value = 8'd3;
        checkOutput("150 ovf early", ovf, 1);
        checkOutput("150 in_ready low", in_ready, 0);
        checkOutput("150 digits held tens", seg_data_1, 4);
        checkOutput("150 digits held units", seg_data_2, 2);
        lat = 0;
        while (!in_ready && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        checkOutput("150 latency", lat, 10);
        checkOutput("150 tens", seg_data_1, 9);
        checkOutput("150 units", seg_data_2, 9);
        checkOutput("150 ovf", ovf, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("3 accepted", in_ready, 0);
        checkOutput("3 ovf cleared", ovf, 0);
        lat = 0;
        while (!in_ready && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        checkOutput("3 latency", lat, 1);
        checkOutput("3 tens", seg_data_1, 0);
        checkOutput("3 units", seg_data_2, 3);
        checkOutput("3 blank_1", blank_1, 1);
        checkOutput("3 ovf", ovf, 0);

        // Async reset three cycles into converting 88.
        @(negedge clk);
        in_valid = 1'b1;
        in_value = 8'd88;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst in_ready", in_ready, 1);
        checkOutput("arst seg_data_1", seg_data_1, 0);
        checkOutput("arst seg_data_2", seg_data_2, 0);
        checkOutput("arst ovf", ovf, 0);
        checkOutput("arst blank_1", blank_1, 1);
        checkOutput("arst blank_2", blank_2, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'd88, lat);
        checkOutput("88 latency", lat, 9);
        checkOutput("88 tens", seg_data_1, 8);
        checkOutput("88 units", seg_data_2, 8);

        // Leading-zero suppression disabled: 5 shows as 0/5 with tens visible.
        @(negedge clk);
        nz_valid = 1'b1;
        nz_value = 8'd5;
        @(posedge clk);
        @(negedge clk);
        nz_valid = 1'b0;
        lat = 0;
        while (!nz_ready && lat < 50) begin
            lat++;
            @(negedge clk);
        end
        checkOutput("nz latency", lat, 1);
        checkOutput("nz tens", nz_data_1, 0);
        checkOutput("nz units", nz_data_2, 5);
        checkOutput("nz blank_1", nz_blank_1, 0);
        checkOutput("nz blank_2", nz_blank_2, 0);
        checkOutput("nz ovf", nz_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seg_ctrl.md
# seg_ctrl

Sequencing controller for the two-digit seven-segment display. It accepts an 8-bit binary value over a valid/ready handshake and converts it to two BCD digits with a sequential subtract-by-ten state machine. It holds those digits on `seg_data_1` (tens) and `seg_data_2` (units) for the downstream segment decoder, and generates per-digit blank strobes for leading-zero suppression and blinking. It sits between the application logic and the decoder; the top level gates each decoder's `seg_led` output with its blank strobe.

## Interface
Parameters:
- `BLINK_DIV`, default 6_000_000: blink half-period in clock cycles (0.5 s at 12 MHz); legal values are ≥ 2.
- `LZ_SUPPRESS`, default 1: when set to 1, the tens digit is blanked whenever it is 0.

Ports:
- `clk`, input, 1: the single system clock. All state is on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: a new value is offered.
- `in_ready`, output, 1: the controller can accept a value.
- `in_value`, input, 8: binary value to display.
- `blink_en`, input, 1: enables blinking of both digits.
- `seg_data_1`, output, 4: tens digit, 0–9.
- `seg_data_2`, output, 4: units digit, 0–9.
- `blank_1`, output, 1: suppress digit 1.
- `blank_2`, output, 1: suppress digit 2.
- `ovf`, output, 1: the last accepted value exceeded 99.

## Operation
- State machine states:
  - IDLE: `in_ready` is 1. On `in_valid & in_ready`:
    - the working remainder is loaded with `min(in_value, 99)`;
    - the tens counter is cleared to 0;
    - `ovf` is set to `(in_value > 99)`;
    - the FSM moves to CONV.
  - CONV: `in_ready` is 0.
    - If remainder ≥ 10: remainder -= 10 and tens += 1, and the FSM stays in CONV.
    - Otherwise (commit): `seg_data_1` <= tens, `seg_data_2` <= remainder[3:0], and the FSM returns to IDLE.
- Widths: the remainder is 7 bits and the tens counter is 4 bits. Neither can overflow because the input is clamped to 99 first.
- `seg_data_1` and `seg_data_2` change only on the commit edge, so the displayed value never shows a partial result.
- `in_valid` while in CONV is ignored (ready is 0). The held value is accepted on the first IDLE cycle.
- Blink prescaler:
  - With `blink_en` = 1, a counter runs 0..BLINK_DIV-1 and toggles `phase` on wrap.
  - With `blink_en` = 0, the counter and `phase` are held at 0.
- Blank outputs, combinational from registered state only:
  - `blank_2 = blink_en & phase`.
  - `blank_1 = (blink_en & phase) | (LZ_SUPPRESS & (seg_data_1 == 0))`.
- Reset values:
  - FSM in IDLE, so `in_ready` = 1.
  - `seg_data_1` = 0, `seg_data_2` = 0, `ovf` = 0.
  - Prescaler = 0 and `phase` = 0, so `blank_2` = 0 and `blank_1` = LZ_SUPPRESS.
- Reset mid-conversion aborts the conversion. All outputs take their reset values immediately; the pending value is discarded.

## Timing
- Accept edge E0. The FSM spends t+1 cycles in CONV, where t = min(v,99)/10. The digits update on edge E0+t+1.
- Latency ranges from 1 cycle (v<10) to 10 cycles (v≥90).
- `in_ready` falls on E0 and rises on the commit edge. Back-to-back throughput is one value per t+2 cycles.
- `ovf` updates on the accept edge, before the digits update. It holds until the next accepted value.
- Blink: the first `phase` toggle occurs BLINK_DIV cycles after `blink_en` rises. Deasserting `blink_en` clears the blanking on the next edge.

## Structure
- Shared package `seg_pkg`:
  - `SEG_DIGIT_W` = 4;
  - `SEG_MAX_VALUE` = 99;
  - the FSM state enum {IDLE, CONV}.
- Sub-module `seg_blink_prescaler` contains the counter and phase register. Its ports are `clk`, `rst`, `en` and `phase`, and it takes parameter `BLINK_DIV`.
- The BCD FSM and the blank logic stay in `seg_ctrl`.

## Test plan
- Reset with no stimulus: `seg_data_1`/`seg_data_2` = 0/0, `in_ready` = 1, `ovf` = 0, `blank_1` = 1, `blank_2` = 0.
- Load 57: `in_ready` is low for exactly 6 cycles. The digits become 5/7 on edge E0+6, `blank_1` = 0, `ovf` = 0.
- Load 150, then load 3 held valid during the conversion:
  - 150 shows 9/9 after 10 cycles with `ovf` = 1.
  - 3 is accepted on the next IDLE cycle, then shows 0/3 with `blank_1` = 1 and `ovf` = 0.
- BLINK_DIV = 4 with `blink_en` = 1 and display 42: `blank_1` and `blank_2` toggle together every 4 cycles. Deasserting `blink_en` gives both blanks = 0 on the next edge.
- Assert `rst` asynchronously 3 cycles into converting 88: outputs return to reset values immediately. After release, loading 88 shows 8/8 after 9 cycles.
- LZ_SUPPRESS = 0, load 5: the display shows 0/5 with `blank_1` = 0.
